// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch-to-decode pipeline register with a one-entry skid so fetch sees a registered ready.
module fetch_buffer #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] ninstr,
    input  logic [ADDR_WIDTH-1:0]  npc,
    input  logic                   nvalid,
    output logic                   nready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   valid,
    input  logic                   ready,
    input  logic                   flush
);
    logic [INSTR_WIDTH-1:0] s_instr;
    logic [ADDR_WIDTH-1:0]  s_pc;
    logic                   s_valid;
    logic                   in_fire;
    logic                   slot_free;

    assign nready    = !s_valid;
    assign in_fire   = nvalid & nready;
    assign slot_free = !valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            s_valid <= 1'b0;
            instr   <= NOP_INSTR;
            pc      <= '0;
            s_instr <= NOP_INSTR;
            s_pc    <= '0;
        end else if (flush) begin
            valid   <= 1'b0;
            s_valid <= 1'b0;
            instr   <= NOP_INSTR;
        end else if (slot_free) begin
            if (s_valid) begin
                instr   <= s_instr;
                pc      <= s_pc;
                valid   <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                instr <= ninstr;
                pc    <= npc;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
                instr <= NOP_INSTR;
            end
        end else if (in_fire) begin
            s_instr <= ninstr;
            s_pc    <= npc;
            s_valid <= 1'b1;
        end
    end

    // the skid only ever fills behind an occupied output slot
    assert property (@(posedge clk) disable iff (rst) !(s_valid && !valid));
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenario tasks plus a randomized queue-model run for fetch_buffer.
module tb_fetch_buffer;
    logic        clk = 0;
    logic        rst, nvalid, ready, flush;
    logic [31:0] ninstr;
    logic [63:0] npc;
    logic        nready, valid;
    logic [31:0] instr;
    logic [63:0] pc;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] i;
        logic [63:0] p;
    } ent_t;

    fetch_buffer dut (
        .clk(clk), .rst(rst), .ninstr(ninstr), .npc(npc), .nvalid(nvalid), .nready(nready),
        .instr(instr), .pc(pc), .valid(valid), .ready(ready), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [63:0] p);
        nvalid = 1; ninstr = i; npc = p;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; ready = 1;
        send(32'hAA, 64'h55);
        step(); step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (nready !== 1'b1) begin errors++; $display("FAIL reset_nready got %0b want 1", nready); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
        nvalid = 0;
        rst = 0;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_nocapture got %0b want 0", valid); end
    endtask

    task automatic test_streaming();
        logic [31:0] ei [3];
        ei[0] = 32'hA1; ei[1] = 32'hA2; ei[2] = 32'hA3;
        ready = 1;
        for (int k = 0; k < 3; k++) begin
            send(ei[k], 64'h1000 + 64'(4 * k));
            step();
            checks++; if (valid !== 1'b1 || instr !== ei[k] || pc !== 64'h1000 + 64'(4 * k))
                begin errors++; $display("FAIL stream_%0d got v=%0b i=%h pc=%h want v=1 i=%h", k, valid, instr, pc, ei[k]); end
            checks++; if (nready !== 1'b1) begin errors++; $display("FAIL stream_nready_%0d got %0b want 1", k, nready); end
        end
        nvalid = 0;
        step();
        checks++; if (valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL stream_drain got v=%0b i=%h want v=0 i=0", valid, instr); end
    endtask

    task automatic test_stall_skid();
        ready = 1;
        send(32'hA1, 64'h2000);
        step();
        ready = 0;
        send(32'hA2, 64'h2004);
        step();
        checks++; if (valid !== 1'b1 || instr !== 32'hA1) begin errors++; $display("FAIL stall_hold got v=%0b i=%h want v=1 i=a1", valid, instr); end
        checks++; if (nready !== 1'b0) begin errors++; $display("FAIL stall_nready got %0b want 0", nready); end
        send(32'hA3, 64'h2008);
        step();
        checks++; if (instr !== 32'hA1 || nready !== 1'b0) begin errors++; $display("FAIL stall_full got i=%h nr=%0b want i=a1 nr=0", instr, nready); end
        ready = 1;
        step();
        checks++; if (valid !== 1'b1 || instr !== 32'hA2 || pc !== 64'h2004) begin errors++; $display("FAIL skid_out got v=%0b i=%h pc=%h want a2 2004", valid, instr, pc); end
        checks++; if (nready !== 1'b1) begin errors++; $display("FAIL skid_nready got %0b want 1", nready); end
        step();
        checks++; if (valid !== 1'b1 || instr !== 32'hA3 || pc !== 64'h2008) begin errors++; $display("FAIL skid_a3 got v=%0b i=%h pc=%h want a3 2008", valid, instr, pc); end
        nvalid = 0;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL skid_drain got %0b want 0", valid); end
    endtask

    task automatic test_flush();
        ready = 0;
        send(32'hD1, 64'h3000);
        step();
        send(32'hD2, 64'h3004);
        step();
        flush = 1;
        send(32'hB0, 64'h3008);
        step();
        flush = 0;
        checks++; if (valid !== 1'b0 || nready !== 1'b1 || instr !== 32'h0) begin errors++; $display("FAIL flush_state got v=%0b nr=%0b i=%h want 0 1 0", valid, nready, instr); end
        checks++; if (pc !== 64'h3000) begin errors++; $display("FAIL flush_pc got %h want 3000", pc); end
        ready = 1;
        send(32'hC0, 64'h300C);
        step();
        checks++; if (valid !== 1'b1 || instr !== 32'hC0 || pc !== 64'h300C) begin errors++; $display("FAIL flush_next got v=%0b i=%h pc=%h want c0 300c", valid, instr, pc); end
        nvalid = 0;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_b0 got %0b want 0", valid); end
    endtask

    task automatic test_reset_stall();
        ready = 0;
        send(32'hF1, 64'h4000);
        step();
        send(32'hF2, 64'h4004);
        step();
        rst = 1; nvalid = 0;
        step();
        rst = 0;
        checks++; if (valid !== 1'b0 || nready !== 1'b1 || pc !== 64'h0) begin errors++; $display("FAIL rst_stall got v=%0b nr=%0b pc=%h want 0 1 0", valid, nready, pc); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_stall_pulse got %0b want 0", valid); end
    endtask

    task automatic test_bubble();
        ready = 1;
        send(32'hE1, 64'h5000);
        step();
        nvalid = 0;
        step();
        checks++; if (valid !== 1'b0 || instr !== 32'h0 || pc !== 64'h5000) begin errors++; $display("FAIL bubble got v=%0b i=%h pc=%h want 0 0 5000", valid, instr, pc); end
        send(32'hE2, 64'h5004);
        step();
        checks++; if (valid !== 1'b1 || instr !== 32'hE2) begin errors++; $display("FAIL bubble_resume got v=%0b i=%h want 1 e2", valid, instr); end
        nvalid = 0;
        step();
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int seq = 0;
        bit hold = 0;
        bit fire;
        ready = 1; flush = 0; nvalid = 0;
        step();
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                nvalid = ($urandom_range(9) < 7);
                seq++;
                ninstr = 32'h1000_0000 + 32'(seq);
                npc = 64'h8000_0000 + 64'(4 * seq);
            end
            ready = ($urandom_range(9) < 6);
            flush = ($urandom_range(19) == 0);
            fire = nvalid && q.size() < 2;
            hold = nvalid && !fire;
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && ready) void'(q.pop_front());
                if (fire) begin e.i = ninstr; e.p = npc; q.push_back(e); end
            end
            step();
            checks++; if (valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid c=%0d got %0b want %0b", c, valid, q.size() > 0); end
            checks++; if (nready !== (q.size() < 2)) begin errors++; $display("FAIL rand_nready c=%0d got %0b want %0b", c, nready, q.size() < 2); end
            checks++; if (!nready && !valid) begin errors++; $display("FAIL rand_skid_only c=%0d got nr=0 v=0 want v=1", c); end
            if (q.size() > 0) begin
                checks++; if (instr !== q[0].i || pc !== q[0].p) begin errors++; $display("FAIL rand_data c=%0d got i=%h pc=%h want i=%h pc=%h", c, instr, pc, q[0].i, q[0].p); end
            end else begin
                checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rand_nop c=%0d got %h want 0", c, instr); end
            end
        end
        flush = 0; nvalid = 0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_reset_stall();
        test_bubble();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Pipeline register between the fetch stage and the decode stage. It is the producer side of the decode stage's input interface.
- Holds one fetched instruction and its PC, presented to decode.
- Adds a one-entry skid register, so fetch sees a registered ready and full throughput is kept under decode stalls.
- Supports a branch flush that discards everything in flight.

Parameters:
- INSTR_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 64, PC width.
- NOP_INSTR, 32'h0000_0000, encoding presented on instr whenever valid is low.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- ninstr  input  INSTR_WIDTH  instruction from fetch.
- npc  input  ADDR_WIDTH  PC of ninstr.
- nvalid  input  1  fetch presents a valid instruction.
- nready  output  1  buffer can accept this cycle; registered.
- instr  output  INSTR_WIDTH  instruction to decode.
- pc  output  ADDR_WIDTH  PC to decode.
- valid  output  1  instr/pc hold a real instruction.
- ready  input  1  decode consumes this cycle; low means decode stall.
- flush  input  1  discard all buffered instructions (taken branch or redirect).

Behaviour:
- State:
  - Output entry: instr, pc, valid.
  - Skid entry: s_instr, s_pc, s_valid.
  - nready = !s_valid, driven directly from the flop.
- Handshakes:
  - in_fire = nvalid & nready.
  - out_fire = valid & ready.
  - Data and pc are only meaningful with their valid. Fetch must hold ninstr/npc stable while nvalid & !nready.
- Priority each cycle: rst > flush > normal.
- Reset (sync):
  - valid=0, s_valid=0, nready=1.
  - instr=NOP_INSTR, pc=0, s_instr=NOP_INSTR, s_pc=0.
  - Reset mid-stall drops both entries with no output pulse.
- Flush:
  - Next cycle: valid=0, s_valid=0, nready=1, instr=NOP_INSTR, pc unchanged.
  - The incoming instruction on the flush cycle is dropped even if in_fire.
  - An out_fire on the flush cycle still counts as consumed; decode owns squashing it.
- Normal, output slot free (!valid | out_fire):
  - If s_valid: output <= skid, s_valid <= 0. If in_fire is also true that cycle (impossible, since nready=0 while s_valid), nothing extra happens.
  - Else if in_fire: output <= {ninstr, npc, 1}.
  - Else: valid <= 0, instr <= NOP_INSTR, pc held.
- Normal, output slot occupied and !ready:
  - If in_fire: skid <= {ninstr, npc}, s_valid <= 1, so nready=0 next cycle.
  - Output entry holds all fields.
- Latency and throughput:
  - 1 cycle from in_fire to valid.
  - With ready held high, one instruction per cycle; nready stays 1.
- Ordering: strict FIFO. The skid entry is always older than any later input; no instruction is duplicated or lost except by flush/rst.
- Capacity: 2 entries. Full = valid & s_valid, giving nready=0. Empty = !valid, which implies !s_valid; s_valid=1 with valid=0 is illegal and must never occur (assertion).
- When ready drops, fetch may have already sent one more instruction. The skid absorbs exactly that one.
- ready asserted while valid=0 has no effect.

Test Plan:
- Reset: hold rst 2 cycles with nvalid=1 -> valid=0, nready=1, instr=32'h0, pc=0. The input is not captured.
- Streaming: ready=1; send {pc 0x1000, instr 0xA1}, {0x1004, 0xA2}, {0x1008, 0xA3} on consecutive cycles -> valid for 3 consecutive cycles starting 1 cycle later, same order; nready never drops.
- Stall and skid: ready=0 after 0xA1 is presented; fetch sends 0xA2 -> skid holds 0xA2, nready=0, 0xA3 is held by fetch. Raise ready -> 0xA1, 0xA2, 0xA3 emerge on consecutive cycles; nready returns to 1 after 0xA2 moves to output.
- Flush while full: valid=1 and s_valid=1; assert flush with nvalid=1 carrying 0xB0 -> next cycle valid=0, nready=1, instr=NOP_INSTR. 0xB0 never appears. The next input 0xC0 appears 1 cycle after its in_fire.
- Bubble: nvalid=0 for one cycle in a stream -> exactly one cycle of valid=0 with instr=NOP_INSTR, and pc equals the last valid pc.
- Random: random nvalid/ready/flush over 10k cycles against a queue model -> order preserved, at most 2 instructions held, s_valid & !valid never occurs.
